dmem_bus_stall_unit: RTL and testbench

//  MEM-stage data-memory bus initiator for the 5-stage core. Turns the MEM-stage load/store into a

---
 rtl/dmem_bus_stall_unit_pkg.sv | 42 ++++
 rtl/dmem_bus_stall_unit_load_align.sv | 29 ++
 rtl/dmem_bus_stall_unit.sv | 158 +++++++++++++++
 tb/tb_dmem_bus_stall_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_stall_unit_pkg.sv
// Shared types and helpers for the MEM-stage data-memory bus initiator.
// Access size decode, FSM state encoding and byte-lane patterns.
package dmem_bus_stall_unit_pkg;

  typedef enum logic [2:0] {
    SIZE_B  = 3'b000,
    SIZE_H  = 3'b001,
    SIZE_W  = 3'b010,
    SIZE_BU = 3'b100,
    SIZE_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } dmem_state_t;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Unused fun3 codes fall back to a full-word access.
  function automatic mem_size_t decode_size(input logic [2:0] fun3);
    case (fun3)
      3'b000:  return SIZE_B;
      3'b001:  return SIZE_H;
      3'b100:  return SIZE_BU;
      3'b101:  return SIZE_HU;
      default: return SIZE_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      SIZE_B, SIZE_BU: return 1'b0;
      SIZE_H, SIZE_HU: return off[0];
      default:         return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bus_stall_unit_load_align.sv
// dmem_load_align: extracts the addressed byte/half from a bus word and
// sign- or zero-extends it according to the access size.
module dmem_load_align
  import dmem_bus_stall_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        off,
  input  mem_size_t         size,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{off, 3'b000} +: 8];
    half_v = word[{off[1], 4'b0000} +: 16];
    case (size)
      SIZE_B:  data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      SIZE_BU: data = {{(DATA_W-8){1'b0}}, byte_v};
      SIZE_H:  data = {{(DATA_W-16){half_v[15]}}, half_v};
      SIZE_HU: data = {{(DATA_W-16){1'b0}}, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_bus_stall_unit.sv
// MEM-stage Wishbone-classic data-memory initiator with pipeline stall.
// Optional REQ timeout abort enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_stall_unit
  import dmem_bus_stall_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mem_to_reg_mem,
  input  logic                mem_write_mem,
  input  logic [2:0]          fun3_mem,
  input  logic [ADDR_W-1:0]   addr_mem,
  input  logic [DATA_W-1:0]   wdata_mem,
  output logic [DATA_W-1:0]   load_data_mem,
  output logic                stall_pipl,
  output logic                misaligned,
  output logic                bus_err,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  dmem_state_t         state;
  mem_size_t           size_q;
  logic [1:0]          off_q;
  logic                load_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   align_out;

  logic                req;
  mem_size_t           size_in;
  logic [1:0]          off_in;
  logic                mis_in;
  logic [DATA_W/8-1:0] sel_in;
  logic [DATA_W-1:0]   dat_in;

  always_comb begin
    req     = mem_to_reg_mem | mem_write_mem;
    size_in = decode_size(fun3_mem);
    off_in  = addr_mem[1:0];
    mis_in  = is_misaligned(size_in, off_in);
    sel_in  = SEL_WORD;
    dat_in  = wdata_mem;
    case (size_in)
      SIZE_B, SIZE_BU: begin
        dat_in = {(DATA_W/8){wdata_mem[7:0]}};
        if (!mem_to_reg_mem) sel_in = SEL_BYTE << off_in;
      end
      SIZE_H, SIZE_HU: begin
        dat_in = {(DATA_W/16){wdata_mem[15:0]}};
        if (!mem_to_reg_mem) sel_in = SEL_HALF << off_in;
      end
      default: ;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             bus_err_q;
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      size_q   <= SIZE_W;
      off_q    <= 2'b00;
      load_q   <= 1'b0;
      rdata_q  <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
`ifdef DMEM_TIMEOUT_EN
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
`ifdef DMEM_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req && !mis_in) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= mem_write_mem && !mem_to_reg_mem;
            wb_adr_o <= {addr_mem[ADDR_W-1:2], 2'b00};
            wb_sel_o <= sel_in;
            wb_dat_o <= dat_in;
            size_q   <= size_in;
            off_q    <= off_in;
            load_q   <= mem_to_reg_mem;
            rdata_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
            state    <= REQ;
          end
        end
        REQ: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (load_q) rdata_q <= wb_dat_i;
            state    <= DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmem_load_align #(.DATA_W(DATA_W)) u_load_align (
    .word (rdata_q),
    .off  (off_q),
    .size (size_q),
    .data (align_out)
  );

  // Stall asserts in the request cycle itself so the pipeline never advances past an unissued access.
  always_comb begin
    stall_pipl    = (state == REQ) || (state == IDLE && req && !mis_in);
    misaligned    = (state == IDLE) && req && mis_in;
    load_data_mem = (state == DONE) ? align_out : '0;
  end

endmodule

// File: tb/tb_dmem_bus_stall_unit.sv
// Directed bench for dmem_bus_stall_unit: vector table of single accesses
// plus reset-abort, stray-ack and (with DMEM_TIMEOUT_EN) timeout sequences.
module tb_dmem_bus_stall_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_to_reg_mem, mem_write_mem;
  logic [2:0]  fun3_mem;
  logic [31:0] addr_mem, wdata_mem;
  logic [31:0] load_data_mem;
  logic        stall_pipl, misaligned, bus_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  dmem_bus_stall_unit #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_to_reg_mem(mem_to_reg_mem), .mem_write_mem(mem_write_mem),
    .fun3_mem(fun3_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .load_data_mem(load_data_mem), .stall_pipl(stall_pipl),
    .misaligned(misaligned), .bus_err(bus_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dat_i;
    int unsigned ack_dly;
    logic        mis;
    logic [31:0] exp_load;
    logic [3:0]  exp_sel;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] dat_i, input int unsigned ack_dly,
                              input logic mis, input logic [31:0] exp_load,
                              input logic [3:0] exp_sel, input logic [31:0] exp_adr,
                              input logic [31:0] exp_dat);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.dat_i = dat_i; v.ack_dly = ack_dly; v.mis = mis; v.exp_load = exp_load;
    v.exp_sel = exp_sel; v.exp_adr = exp_adr; v.exp_dat = exp_dat;
    return v;
  endfunction

  task automatic idle_inputs();
    mem_to_reg_mem = 1'b0;
    mem_write_mem  = 1'b0;
    fun3_mem       = 3'b010;
    addr_mem       = '0;
    wdata_mem      = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned n_stall;
    int unsigned n_req;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    mem_to_reg_mem = v.ld;
    mem_write_mem  = v.st;
    fun3_mem       = v.f3;
    addr_mem       = v.addr;
    wdata_mem      = v.wdata;
    wb_ack_i       = 1'b0;
    #1;
    if (v.mis) begin
      chk({tag, "_mis"}, {31'd0, misaligned}, 32'd1);
      chk({tag, "_mis_stall"}, {31'd0, stall_pipl}, 32'd0);
      chk({tag, "_mis_load"}, load_data_mem, 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      chk({tag, "_mis_nocyc"}, {31'd0, wb_cyc_o}, 32'd0);
      chk({tag, "_mis_pulse_end"}, {31'd0, misaligned}, 32'd0);
      return;
    end
    n_stall = 0;
    n_req   = 0;
    while (stall_pipl === 1'b1 && n_stall < 40) begin
      n_stall++;
      if (wb_cyc_o === 1'b1) begin
        n_req++;
        if (n_req == 1) begin
          chk({tag, "_adr"}, wb_adr_o, v.exp_adr);
          chk({tag, "_sel"}, {28'd0, wb_sel_o}, {28'd0, v.exp_sel});
          chk({tag, "_we"}, {31'd0, wb_we_o}, {31'd0, v.st});
          chk({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd1);
          if (v.st) chk({tag, "_dat"}, wb_dat_o, v.exp_dat);
        end
        wb_ack_i = (n_req == v.ack_dly);
        wb_dat_i = v.dat_i;
      end
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h5A5A_A5A5;
      #1;
    end
    chk({tag, "_stall_cycles"}, n_stall, v.ack_dly + 1);
    chk({tag, "_done_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
    chk({tag, "_load"}, load_data_mem, v.exp_load);
    chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    idle_inputs();
    @(negedge clk);
    #1;
    chk({tag, "_idle_load"}, load_data_mem, 32'd0);
  endtask

  initial begin
    int unsigned n;
    reset_n  = 1'b0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    idle_inputs();

    //            ld    st    f3      addr          wdata         dat_i         dly mis  exp_load      sel      adr           dat
    vecs[0]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0100, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h8012_3456, 1, 1'b0, 32'hFFFF_FF80, 4'b1111, 32'h0000_0200, 32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h8012_3456, 2, 1'b0, 32'h0000_0080, 4'b1111, 32'h0000_0200, 32'h0);
    vecs[3]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 32'h1111_1111, 1, 1'b0, 32'h0000_0000, 4'b1100, 32'h0000_0300, 32'hABCD_ABCD);
    vecs[4]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0402, 32'h0,        32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[5]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 2, 1'b0, 32'hFFFF_8001, 4'b1111, 32'h0000_0100, 32'h0);
    vecs[6]  = mk(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 1'b0, 32'h0000_8001, 4'b1111, 32'h0000_0100, 32'h0);
    vecs[7]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h1234_5678, 32'h0,        2, 1'b0, 32'h0000_0000, 4'b0010, 32'h0000_0010, 32'h7878_7878);
    vecs[8]  = mk(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,        1, 1'b0, 32'h0000_0000, 4'b1111, 32'h0000_0020, 32'hCAFE_F00D);
    vecs[9]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0000_1234, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[10] = mk(1'b1, 1'b0, 3'b011, 32'h0000_0044, 32'h0,        32'h1122_3344, 1, 1'b0, 32'h1122_3344, 4'b1111, 32'h0000_0044, 32'h0);
    vecs[11] = mk(1'b1, 1'b0, 3'b111, 32'h0000_0045, 32'h0,        32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[12] = mk(1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 1, 1'b0, 32'h0000_007F, 4'b1111, 32'h0000_0000, 32'h0);
    vecs[13] = mk(1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h1234_FFFE, 4, 1'b0, 32'hFFFF_FFFE, 4'b1111, 32'h0000_0000, 32'h0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_stall", {31'd0, stall_pipl}, 32'd0);
    chk("rst_load", load_data_mem, 32'd0);
    chk("rst_flags", {30'd0, misaligned, bus_err}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Stray ack while idle must not start or disturb anything.
    @(negedge clk);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    chk("stray_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("stray_ack_stall", {31'd0, stall_pipl}, 32'd0);
    chk("stray_ack_load", load_data_mem, 32'd0);
    wb_ack_i = 1'b0;

    // Reset while waiting in REQ aborts the access without a DONE cycle.
    @(negedge clk);
    mem_to_reg_mem = 1'b1;
    fun3_mem       = 3'b010;
    addr_mem       = 32'h0000_0500;
    @(negedge clk);
    #1;
    chk("rreq_cyc", {31'd0, wb_cyc_o}, 32'd1);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1;
    chk("rreq_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk("rreq_stall", {31'd0, stall_pipl}, 32'd0);
    reset_n  = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("late_ack_cyc%0d", c), {31'd0, wb_cyc_o}, 32'd0);
      chk($sformatf("late_ack_stall%0d", c), {31'd0, stall_pipl}, 32'd0);
      chk($sformatf("late_ack_load%0d", c), load_data_mem, 32'd0);
    end
    wb_ack_i = 1'b0;

`ifdef DMEM_TIMEOUT_EN
    @(negedge clk);
    mem_to_reg_mem = 1'b1;
    fun3_mem       = 3'b010;
    addr_mem       = 32'h0000_0600;
    @(negedge clk);
    #1;
    n = 0;
    while (wb_cyc_o === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    idle_inputs();
    chk("tmo_req_cycles", n, 32'd8);
    chk("tmo_bus_err", {31'd0, bus_err}, 32'd1);
    chk("tmo_stall", {31'd0, stall_pipl}, 32'd0);
    chk("tmo_load", load_data_mem, 32'd0);
    @(negedge clk);
    #1;
    chk("tmo_bus_err_pulse", {31'd0, bus_err}, 32'd0);
`else
    n = 0;
    chk("no_tmo_bus_err", {31'd0, bus_err}, 32'(n));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
